// File: rtl/axi_lite_arbiter.sv
// Shares one AXI4-Lite slave between NUM_MASTERS masters with independent read/write arbitration.
// Build option: define AXI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (default round-robin).
package axi_lite_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              ready;
  } axi_lite_addr_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              valid;
    logic              ready;
  } axi_lite_w_t;

  typedef struct packed {
    logic [RESP_W-1:0] resp;
    logic              valid;
    logic              ready;
  } axi_lite_b_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              valid;
    logic              ready;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_addr_t aw;
    axi_lite_w_t    w;
    axi_lite_b_t    b;
    axi_lite_addr_t ar;
    axi_lite_r_t    r;
  } axi_lite_bus_t;
endpackage

// state  | meaning
// W_IDLE | no write owner, picking a winner from aw.valid requests
// W_XFER | owner's AW and W routed to the slave until both handshakes are done
// W_RESP | slave B routed back to the owner until the B handshake
// R_IDLE | no read owner, picking a winner from ar.valid requests
// R_ADDR | owner's AR routed to the slave until its handshake
// R_DATA | slave R routed back to the owner until the R handshake
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  axi_lite_bus_t          m_in  [NUM_MASTERS],
  output axi_lite_bus_t          m_out [NUM_MASTERS],
  input  axi_lite_bus_t          s_in,
  output axi_lite_bus_t          s_out,
  output logic [NUM_MASTERS-1:0] wr_grant,
  output logic [NUM_MASTERS-1:0] rd_grant
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

  wr_state_t wr_state, wr_state_n;
  rd_state_t rd_state, rd_state_n;
  logic [NUM_MASTERS-1:0] wr_grant_n, rd_grant_n;
  logic [NUM_MASTERS-1:0] wr_req, rd_req, wr_pick, rd_pick;
  logic aw_done, aw_done_n, w_done, w_done_n;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic [ADDR_W-1:0] g_awaddr, g_araddr;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;
  logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      wr_req[i] = m_in[i].aw.valid;
      rd_req[i] = m_in[i].ar.valid;
    end
  end

`ifdef AXI_ARB_FIXED_PRIO_EN
  function automatic logic [NUM_MASTERS-1:0] prio_pick(input logic [NUM_MASTERS-1:0] req);
    logic [NUM_MASTERS-1:0] g;
    g = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (|(req & (NUM_MASTERS'(1) << k))) g = NUM_MASTERS'(1) << k;
    end
    return g;
  endfunction

  assign wr_pick = prio_pick(wr_req);
  assign rd_pick = prio_pick(rd_req);
`else
  logic [IDX_W-1:0] last_w, last_r;

  // Walk downwards so the index nearest to last+1 is the final (winning) assignment.
  function automatic logic [NUM_MASTERS-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                     input logic [IDX_W-1:0] last);
    logic [NUM_MASTERS-1:0] g;
    int idx;
    g = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_MASTERS;
      if (|(req & (NUM_MASTERS'(1) << idx))) g = NUM_MASTERS'(1) << idx;
    end
    return g;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (|(oh & (NUM_MASTERS'(1) << k))) idx = IDX_W'(k);
    end
    return idx;
  endfunction

  assign wr_pick = rr_pick(wr_req, last_w);
  assign rd_pick = rr_pick(rd_req, last_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_w <= IDX_W'(NUM_MASTERS - 1);
      last_r <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      if (wr_state == W_RESP && b_hs) last_w <= onehot_to_idx(wr_grant);
      if (rd_state == R_DATA && r_hs) last_r <= onehot_to_idx(rd_grant);
    end
  end
`endif

  always_comb begin
    g_awaddr  = '0;
    g_awvalid = 1'b0;
    g_wdata   = '0;
    g_wstrb   = '0;
    g_wvalid  = 1'b0;
    g_bready  = 1'b0;
    g_araddr  = '0;
    g_arvalid = 1'b0;
    g_rready  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (wr_grant[i]) begin
        g_awaddr  = m_in[i].aw.addr;
        g_awvalid = m_in[i].aw.valid;
        g_wdata   = m_in[i].w.data;
        g_wstrb   = m_in[i].w.strb;
        g_wvalid  = m_in[i].w.valid;
        g_bready  = m_in[i].b.ready;
      end
      if (rd_grant[i]) begin
        g_araddr  = m_in[i].ar.addr;
        g_arvalid = m_in[i].ar.valid;
        g_rready  = m_in[i].r.ready;
      end
    end
  end

  // Completed channels stay masked so the slave never sees a repeated beat.
  always_comb begin
    s_out = '0;
    if (wr_state == W_XFER) begin
      s_out.aw.addr  = g_awaddr;
      s_out.aw.valid = g_awvalid & ~aw_done;
      s_out.w.data   = g_wdata;
      s_out.w.strb   = g_wstrb;
      s_out.w.valid  = g_wvalid & ~w_done;
    end
    if (wr_state == W_RESP) s_out.b.ready = g_bready;
    if (rd_state == R_ADDR) begin
      s_out.ar.addr  = g_araddr;
      s_out.ar.valid = g_arvalid;
    end
    if (rd_state == R_DATA) s_out.r.ready = g_rready;
  end

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_out[i] = '0;
      if (wr_grant[i] && wr_state == W_XFER) begin
        m_out[i].aw.ready = s_in.aw.ready & ~aw_done;
        m_out[i].w.ready  = s_in.w.ready & ~w_done;
      end
      if (wr_grant[i] && wr_state == W_RESP) begin
        m_out[i].b.valid = s_in.b.valid;
        m_out[i].b.resp  = s_in.b.resp;
      end
      if (rd_grant[i] && rd_state == R_ADDR) m_out[i].ar.ready = s_in.ar.ready;
      if (rd_grant[i] && rd_state == R_DATA) begin
        m_out[i].r.valid = s_in.r.valid;
        m_out[i].r.data  = s_in.r.data;
        m_out[i].r.resp  = s_in.r.resp;
      end
    end
  end

  assign aw_hs = s_out.aw.valid & s_in.aw.ready;
  assign w_hs  = s_out.w.valid & s_in.w.ready;
  assign b_hs  = s_in.b.valid & s_out.b.ready;
  assign ar_hs = s_out.ar.valid & s_in.ar.ready;
  assign r_hs  = s_in.r.valid & s_out.r.ready;

  always_comb begin
    wr_state_n = wr_state;
    wr_grant_n = wr_grant;
    aw_done_n  = aw_done;
    w_done_n   = w_done;
    case (wr_state)
      W_IDLE: begin
        if (|wr_req) begin
          wr_grant_n = wr_pick;
          aw_done_n  = 1'b0;
          w_done_n   = 1'b0;
          wr_state_n = W_XFER;
        end
      end
      W_XFER: begin
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_hs;
        if (aw_done_n && w_done_n) wr_state_n = W_RESP;
      end
      W_RESP: begin
        if (b_hs) begin
          wr_grant_n = '0;
          wr_state_n = W_IDLE;
        end
      end
      default: begin
        wr_grant_n = '0;
        wr_state_n = W_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_state_n = rd_state;
    rd_grant_n = rd_grant;
    case (rd_state)
      R_IDLE: begin
        if (|rd_req) begin
          rd_grant_n = rd_pick;
          rd_state_n = R_ADDR;
        end
      end
      R_ADDR: if (ar_hs) rd_state_n = R_DATA;
      R_DATA: begin
        if (r_hs) begin
          rd_grant_n = '0;
          rd_state_n = R_IDLE;
        end
      end
      default: begin
        rd_grant_n = '0;
        rd_state_n = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      wr_grant <= '0;
      rd_grant <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      rd_state <= rd_state_n;
      wr_grant <= wr_grant_n;
      rd_grant <= rd_grant_n;
      aw_done  <= aw_done_n;
      w_done   <= w_done_n;
    end
  end

  // Fields flowing in the opposite direction are never looked at.
  logic                   unused_s_in;
  logic [NUM_MASTERS-1:0] unused_m_in;

  assign unused_s_in = ^{s_in.aw.addr, s_in.aw.valid, s_in.w.data, s_in.w.strb, s_in.w.valid,
                         s_in.b.ready, s_in.ar.addr, s_in.ar.valid, s_in.r.ready};

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unused
    assign unused_m_in[gi] = ^{m_in[gi].aw.ready, m_in[gi].w.ready, m_in[gi].b.resp,
                               m_in[gi].b.valid, m_in[gi].ar.ready, m_in[gi].r.data,
                               m_in[gi].r.resp, m_in[gi].r.valid};
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with a small zero/limited-wait slave model.
module tb_axi_lite_arbiter;
  import axi_lite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  axi_lite_bus_t m_in  [2];
  axi_lite_bus_t m_out [2];
  axi_lite_bus_t s_in;
  axi_lite_bus_t s_out;
  logic [1:0] wr_grant, rd_grant;

  axi_lite_arbiter #(.NUM_MASTERS(2)) dut (
    .clk(clk), .rst(rst), .m_in(m_in), .m_out(m_out),
    .s_in(s_in), .s_out(s_out), .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // slave model
  logic s_awready = 1'b1, s_wready = 1'b1, s_arready = 1'b1;
  logic [1:0]  s_rresp  = RESP_OKAY;
  logic [31:0] rd_value = 32'h0;
  logic s_bvalid = 1'b0, s_rvalid = 1'b0, have_aw = 1'b0, have_w = 1'b0;
  logic [31:0] s_rdata = 32'h0, cap_addr = 32'h0, cap_data = 32'h0;
  logic [1:0]  s_rresp_q = 2'b00;
  logic [3:0]  cap_strb = 4'h0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
  wire aw_h = s_out.aw.valid & s_in.aw.ready;
  wire w_h  = s_out.w.valid & s_in.w.ready;
  wire b_h  = s_in.b.valid & s_out.b.ready;
  wire ar_h = s_out.ar.valid & s_in.ar.ready;
  wire r_h  = s_in.r.valid & s_out.r.ready;

  always_comb begin
    s_in          = '0;
    s_in.aw.ready = s_awready;
    s_in.w.ready  = s_wready;
    s_in.b.valid  = s_bvalid;
    s_in.b.resp   = RESP_OKAY;
    s_in.ar.ready = s_arready;
    s_in.r.valid  = s_rvalid;
    s_in.r.data   = s_rdata;
    s_in.r.resp   = s_rresp_q;
  end

  always @(posedge clk) begin
    if (rst) begin
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      have_aw  <= 1'b0;
      have_w   <= 1'b0;
    end else begin
      if (aw_h) begin aw_cnt <= aw_cnt + 1; cap_addr <= s_out.aw.addr; end
      if (w_h) begin w_cnt <= w_cnt + 1; cap_data <= s_out.w.data; cap_strb <= s_out.w.strb; end
      if (b_h) begin
        s_bvalid <= 1'b0;
        b_cnt    <= b_cnt + 1;
      end else if (!s_bvalid && (have_aw | aw_h) && (have_w | w_h)) begin
        s_bvalid <= 1'b1;
        have_aw  <= 1'b0;
        have_w   <= 1'b0;
      end else begin
        if (aw_h) have_aw <= 1'b1;
        if (w_h) have_w <= 1'b1;
      end
      if (r_h) s_rvalid <= 1'b0;
      else if (ar_h) begin
        s_rvalid  <= 1'b1;
        s_rdata   <= rd_value;
        s_rresp_q <= s_rresp;
        ar_cnt    <= ar_cnt + 1;
      end
    end
  end

  // write grant log: one entry per new grant
  logic [1:0] wr_log[$];
  logic [1:0] prev_wg = 2'b00;
  always @(posedge clk) begin
    prev_wg <= wr_grant;
    if (wr_grant != 2'b00 && prev_wg == 2'b00) wr_log.push_back(wr_grant);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_txn(input int m, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [1:0] resp);
    logic got, awh, wh, bh;
    int cyc;
    m_in[m].aw.addr  = a;
    m_in[m].aw.valid = 1'b1;
    m_in[m].w.data   = d;
    m_in[m].w.strb   = s;
    m_in[m].w.valid  = 1'b1;
    m_in[m].b.ready  = 1'b1;
    got  = 1'b0;
    cyc  = 0;
    resp = 2'bxx;
    while (!got && cyc < 30) begin
      #1;
      awh = m_in[m].aw.valid && m_out[m].aw.ready;
      wh  = m_in[m].w.valid && m_out[m].w.ready;
      bh  = m_out[m].b.valid && m_in[m].b.ready;
      if (bh) resp = m_out[m].b.resp;
      tick();
      cyc++;
      if (awh) m_in[m].aw.valid = 1'b0;
      if (wh) m_in[m].w.valid = 1'b0;
      if (bh) got = 1'b1;
    end
    m_in[m].aw.valid = 1'b0;
    m_in[m].w.valid  = 1'b0;
    m_in[m].b.ready  = 1'b0;
    check($sformatf("wr_done_m%0d", m), got, 1);
  endtask

  task automatic rd_txn(input int m, input logic [31:0] a, output logic [31:0] d,
                        output logic [1:0] resp, output logic other_rvalid, output int cyc);
    logic got, arh, rh;
    m_in[m].ar.addr  = a;
    m_in[m].ar.valid = 1'b1;
    m_in[m].r.ready  = 1'b1;
    got = 1'b0;
    cyc = 0;
    d = 'x;
    resp = 'x;
    other_rvalid = 1'b0;
    while (!got && cyc < 30) begin
      #1;
      arh = m_in[m].ar.valid && m_out[m].ar.ready;
      rh  = m_out[m].r.valid && m_in[m].r.ready;
      for (int j = 0; j < 2; j++) if (j != m && m_out[j].r.valid) other_rvalid = 1'b1;
      if (rh) begin d = m_out[m].r.data; resp = m_out[m].r.resp; end
      tick();
      cyc++;
      if (arh) m_in[m].ar.valid = 1'b0;
      if (rh) got = 1'b1;
    end
    m_in[m].ar.valid = 1'b0;
    m_in[m].r.ready  = 1'b0;
    check($sformatf("rd_done_m%0d", m), got, 1);
  endtask

  logic [1:0] exp_log [8];
  logic [1:0] resp0, resp1, rresp;
  logic [31:0] rdata;
  logic other_rv;
  int rcyc, base_aw, base_w, base_b;

  initial begin
`ifdef AXI_ARB_FIXED_PRIO_EN
    exp_log = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
`else
    exp_log = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    m_in[0] = '0;
    m_in[1] = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_wr_grant", wr_grant, 2'b00);
    check("rst_rd_grant", rd_grant, 2'b00);
    check("rst_s_out_zero", |s_out, 1'b0);
    check("rst_m_out0_zero", |m_out[0], 1'b0);
    check("rst_m_out1_zero", |m_out[1], 1'b0);
    rst = 1'b0;
    tick();

    // reset while stuck in W_XFER
    s_awready = 1'b0;
    s_wready  = 1'b0;
    base_aw   = aw_cnt;
    m_in[0].aw.addr  = 32'h80;
    m_in[0].aw.valid = 1'b1;
    m_in[0].w.data   = 32'h1;
    m_in[0].w.strb   = 4'hF;
    m_in[0].w.valid  = 1'b1;
    tick();
    tick();
    check("midrst_grant_before", wr_grant, 2'b01);
    check("midrst_awvalid_before", s_out.aw.valid, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_grant", wr_grant, 2'b00);
    check("midrst_awvalid", s_out.aw.valid, 1'b0);
    check("midrst_bvalid", {m_out[1].b.valid, m_out[0].b.valid}, 2'b00);
    tick();
    m_in[0] = '0;
    rst = 1'b0;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    tick();
    check("midrst_idle_after", wr_grant, 2'b00);
    check("midrst_no_aw_hs", aw_cnt - base_aw, 0);

    // single write from master 1
    base_b = b_cnt;
    m_in[1].aw.addr  = 32'h10;
    m_in[1].aw.valid = 1'b1;
    m_in[1].w.data   = 32'hDEADBEEF;
    m_in[1].w.strb   = 4'hF;
    m_in[1].w.valid  = 1'b1;
    m_in[1].b.ready  = 1'b1;
    #1;
    check("single_no_early_valid", s_out.aw.valid, 1'b0);
    tick();
    check("single_grant_c1", wr_grant, 2'b10);
    check("single_s_awaddr", s_out.aw.addr, 32'h10);
    check("single_s_wdata", s_out.w.data, 32'hDEADBEEF);
    check("single_s_wvalid", {s_out.aw.valid, s_out.w.valid}, 2'b11);
    check("single_m0_awready", m_out[0].aw.ready, 1'b0);
    tick();
    m_in[1].aw.valid = 1'b0;
    m_in[1].w.valid  = 1'b0;
    #1;
    check("single_grant_c2", wr_grant, 2'b10);
    check("single_bvalid", m_out[1].b.valid, 1'b1);
    check("single_bresp", m_out[1].b.resp, RESP_OKAY);
    check("single_m0_bvalid", m_out[0].b.valid, 1'b0);
    tick();
    m_in[1].b.ready = 1'b0;
    check("single_grant_end", wr_grant, 2'b00);
    check("single_cap", {cap_addr, cap_data}, {32'h10, 32'hDEADBEEF});
    check("single_cap_strb", cap_strb, 4'hF);
    check("single_b_count", b_cnt - base_b, 1);

    // contention: 4 writes each from masters 0 and 1
    wr_log.delete();
    base_aw = aw_cnt;
    base_w  = w_cnt;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          wr_txn(0, 32'h100 + 32'(k), 32'hA000 + 32'(k), 4'hF, resp0);
          check("cont_resp_m0", resp0, RESP_OKAY);
        end
      end
      begin
        for (int k = 0; k < 4; k++) begin
          wr_txn(1, 32'h200 + 32'(k), 32'hB000 + 32'(k), 4'hF, resp1);
          check("cont_resp_m1", resp1, RESP_OKAY);
        end
      end
    join
    check("cont_log_size", wr_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < wr_log.size()) check($sformatf("cont_grant_%0d", k), wr_log[k], exp_log[k]);
    end
    check("cont_aw_count", aw_cnt - base_aw, 8);
    check("cont_w_count", w_cnt - base_w, 8);
    tick();

    // W presented 3 cycles before AW; slave also holds off AW
    base_aw = aw_cnt;
    base_w  = w_cnt;
    base_b  = b_cnt;
    s_awready = 1'b0;
    m_in[0].w.data  = 32'h11112222;
    m_in[0].w.strb  = 4'h3;
    m_in[0].w.valid = 1'b1;
    m_in[0].b.ready = 1'b1;
    tick();
    tick();
    tick();
    check("wfirst_no_grant", wr_grant, 2'b00);
    m_in[0].aw.addr  = 32'h40;
    m_in[0].aw.valid = 1'b1;
    tick();
    check("wfirst_grant", wr_grant, 2'b01);
    tick();
    check("wfirst_w_masked", s_out.w.valid, 1'b0);
    check("wfirst_aw_pending", s_out.aw.valid, 1'b1);
    s_awready = 1'b1;
    tick();
    m_in[0].aw.valid = 1'b0;
    #1;
    check("wfirst_bvalid", m_out[0].b.valid, 1'b1);
    tick();
    m_in[0].w.valid = 1'b0;
    m_in[0].b.ready = 1'b0;
    tick();
    tick();
    check("wfirst_grant_end", wr_grant, 2'b00);
    check("wfirst_counts", {8'(aw_cnt - base_aw), 8'(w_cnt - base_w), 8'(b_cnt - base_b)},
          {8'd1, 8'd1, 8'd1});
    check("wfirst_cap", {cap_addr, cap_data}, {32'h40, 32'h11112222});

    // read by master 0 overlapping write by master 1
    rd_value = 32'hCAFE0020;
    s_rresp  = RESP_OKAY;
    m_in[0].ar.addr  = 32'h20;
    m_in[0].ar.valid = 1'b1;
    m_in[0].r.ready  = 1'b1;
    m_in[1].aw.addr  = 32'h20;
    m_in[1].aw.valid = 1'b1;
    m_in[1].w.data   = 32'h5;
    m_in[1].w.strb   = 4'hF;
    m_in[1].w.valid  = 1'b1;
    m_in[1].b.ready  = 1'b1;
    tick();
    check("ovl_grants", {wr_grant, rd_grant}, {2'b10, 2'b01});
    check("ovl_s_araddr", s_out.ar.addr, 32'h20);
    check("ovl_s_arvalid", s_out.ar.valid, 1'b1);
    check("ovl_s_awaddr_wdata", {s_out.aw.addr, s_out.w.data}, {32'h20, 32'h5});
    tick();
    m_in[0].ar.valid = 1'b0;
    m_in[1].aw.valid = 1'b0;
    m_in[1].w.valid  = 1'b0;
    #1;
    check("ovl_r_valid", {m_out[1].r.valid, m_out[0].r.valid}, 2'b01);
    check("ovl_r_data", m_out[0].r.data, 32'hCAFE0020);
    check("ovl_r_resp", m_out[0].r.resp, RESP_OKAY);
    check("ovl_b_valid", {m_out[1].b.valid, m_out[0].b.valid}, 2'b10);
    tick();
    m_in[0].r.ready = 1'b0;
    m_in[1].b.ready = 1'b0;
    check("ovl_grants_end", {wr_grant, rd_grant}, 4'b0000);
    check("ovl_cap_data", cap_data, 32'h5);

    // slave error on a read from master 1
    rd_value = 32'h12345678;
    s_rresp  = RESP_SLVERR;
    rd_txn(1, 32'h44, rdata, rresp, other_rv, rcyc);
    check("slverr_resp", rresp, 2'b10);
    check("slverr_data", rdata, 32'h12345678);
    check("slverr_other_rvalid", other_rv, 1'b0);
    check("slverr_cycles", rcyc, 3);
    check("slverr_rd_grant_end", rd_grant, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
